// File: rtl/sysid_regs_pkg.sv
// Shared constants and helpers for the system-identification register slave:
// word addresses, CONTROL bit positions, CAPS field layout and byte-lane merge.
package sysid_regs_pkg;

    localparam int ADDR_ID        = 0;
    localparam int ADDR_TIMESTAMP = 1;
    localparam int ADDR_VERSION   = 2;
    localparam int ADDR_CAPS      = 3;
    localparam int ADDR_SCRATCH   = 4;
    localparam int ADDR_UPTIME_LO = 5;
    localparam int ADDR_UPTIME_HI = 6;
    localparam int ADDR_CONTROL   = 7;
    localparam int ADDR_USER0     = 8;

    localparam int CTRL_CLEAR  = 0;
    localparam int CTRL_FREEZE = 1;

    localparam logic [31:0] UNMAPPED_VALUE = 32'h0;

    localparam int CAPS_NUM_USER_LSB = 0;
    localparam int CAPS_HB_LSB       = 8;
    localparam int CAPS_FIELD_W      = 8;

    function automatic logic [31:0] caps_word(input int num_user, input int hb_div);
        logic [31:0] w;
        w = 32'h0;
        w[CAPS_NUM_USER_LSB +: CAPS_FIELD_W] = 8'(num_user);
        w[CAPS_HB_LSB +: CAPS_FIELD_W]       = 8'(hb_div != 0);
        return w;
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  be);
        logic [31:0] m;
        m = old_word;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                m[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/sysid_uptime.sv
// 64-bit free-running uptime counter with freeze, synchronous clear and a
// high-word shadow captured whenever the low word is read, so a lo-then-hi
// read pair always describes the same instant.
module sysid_uptime
    import sysid_regs_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        freeze,
    input  logic        snap,
    output logic [63:0] uptime,
    output logic [31:0] hi_shadow
);

    logic [63:0] count;

    // Counter: clear takes priority over both increment and wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= 64'h0;
        end else if (clear) begin
            count <= 64'h0;
        end else if (!freeze) begin
            count <= count + 64'd1;
        end
    end

    // Shadow latches the live high word on a low-word read; clear zeroes it too.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_shadow <= 32'h0;
        end else if (clear) begin
            hi_shadow <= 32'h0;
        end else if (snap) begin
            hi_shadow <= count[63:32];
        end
    end

    assign uptime = count;

endmodule

// File: rtl/sysid_regs.sv
// Avalon-MM system-identification and housekeeping slave. Constant ID words,
// a byte-enabled scratch register, a 64-bit uptime counter with coherent
// snapshot, sampled user status words and a heartbeat square wave.
// Fixed one-cycle read latency, no waitrequest.
module sysid_regs
    import sysid_regs_pkg::*;
#(
    parameter logic [31:0] SYSTEM_ID = 32'd1193057379,
    parameter logic [31:0] TIMESTAMP = 32'd1330643110,
    parameter logic [31:0] VERSION   = 32'h0002_0000,
    parameter int          NUM_USER  = 4,
    parameter int          ADDR_W    = 4,
    parameter int          HB_DIV    = 50_000_000
)
(
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   address,
    input  logic                read,
    input  logic                write,
    input  logic [31:0]         writedata,
    input  logic [3:0]          byteenable,
    output logic [31:0]         readdata,
    output logic                readdatavalid,
    input  logic [(NUM_USER > 0 ? 32*NUM_USER : 32)-1:0] user_status,
    output logic                heartbeat
);

    // A zero-word user bank still keeps one (never addressed) sample register.
    localparam int NU_W = (NUM_USER > 0) ? NUM_USER : 1;
    localparam int HB_W = (HB_DIV > 1) ? $clog2(HB_DIV) : 1;
    localparam logic [HB_W-1:0]  HB_LAST   = HB_W'(HB_DIV - 1);
    localparam logic [31:0]      CAPS_WORD = caps_word(NUM_USER, HB_DIV);

    logic [31:0]     addr_full;
    logic [31:0]     scratch;
    logic            freeze;
    logic [31:0]     ctrl_word;
    logic [31:0]     user_q [NU_W];
    logic [31:0]     rd_mux;
    logic            wr_scratch;
    logic            wr_ctrl;
    logic            clear_req;
    logic            snap_req;
    logic [63:0]     uptime;
    logic [31:0]     hi_shadow;
    logic [HB_W-1:0] hb_div;

    assign addr_full  = 32'(address);
    assign wr_scratch = write && (addr_full == 32'(ADDR_SCRATCH));
    assign wr_ctrl    = write && (addr_full == 32'(ADDR_CONTROL));
    // The clear bit is not stored; it acts as a one-shot on the write edge.
    assign clear_req  = wr_ctrl && byteenable[0] && writedata[CTRL_CLEAR];
    assign snap_req   = read && (addr_full == 32'(ADDR_UPTIME_LO));

    sysid_uptime u_uptime (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear_req),
        .freeze    (freeze),
        .snap      (snap_req),
        .uptime    (uptime),
        .hi_shadow (hi_shadow)
    );

    // Scratch register, written per byte lane.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scratch <= 32'h0;
        end else if (wr_scratch) begin
            scratch <= merge_bytes(scratch, writedata, byteenable);
        end
    end

    // Freeze is the only stored CONTROL bit; it lives in byte lane 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            freeze <= 1'b0;
        end else if (wr_ctrl && byteenable[0]) begin
            freeze <= writedata[CTRL_FREEZE];
        end
    end

    // CONTROL readback: clear always reads 0, upper bits reserved as 0.
    always_comb begin
        ctrl_word              = 32'h0;
        ctrl_word[CTRL_FREEZE] = freeze;
    end

    // User status words are resampled every cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NU_W; k++) begin
                user_q[k] <= 32'h0;
            end
        end else begin
            for (int k = 0; k < NU_W; k++) begin
                user_q[k] <= user_status[32*k +: 32];
            end
        end
    end

    // Read mux works from current (pre-write) register contents.
    always_comb begin
        rd_mux = UNMAPPED_VALUE;
        case (addr_full)
            32'(ADDR_ID):        rd_mux = SYSTEM_ID;
            32'(ADDR_TIMESTAMP): rd_mux = TIMESTAMP;
            32'(ADDR_VERSION):   rd_mux = VERSION;
            32'(ADDR_CAPS):      rd_mux = CAPS_WORD;
            32'(ADDR_SCRATCH):   rd_mux = scratch;
            32'(ADDR_UPTIME_LO): rd_mux = uptime[31:0];
            32'(ADDR_UPTIME_HI): rd_mux = hi_shadow;
            32'(ADDR_CONTROL):   rd_mux = ctrl_word;
            default: begin
                for (int k = 0; k < NUM_USER; k++) begin
                    if (addr_full == 32'(ADDR_USER0 + k)) begin
                        rd_mux = user_q[k];
                    end
                end
            end
        endcase
    end

    // Read response register: one-cycle latency, data held between responses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata      <= 32'h0;
            readdatavalid <= 1'b0;
        end else begin
            readdatavalid <= read;
            if (read) begin
                readdata <= rd_mux;
            end
        end
    end

    // Heartbeat divider: toggles the output each time it wraps past HB_DIV-1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hb_div    <= '0;
            heartbeat <= 1'b0;
        end else if (hb_div == HB_LAST) begin
            hb_div    <= '0;
            heartbeat <= ~heartbeat;
        end else begin
            hb_div    <= hb_div + HB_W'(1);
        end
    end

endmodule

// File: tb/tb_sysid_regs.sv
// Self-checking bench for sysid_regs: a table of single-cycle bus operations
// followed by hand-written sequences for uptime wrap/snapshot, freeze/clear,
// user status sampling, heartbeat timing and reset during a read.
module tb_sysid_regs;

    localparam logic [31:0] SYS_ID  = 32'd1193057379;
    localparam logic [31:0] TS      = 32'd1330643110;
    localparam logic [31:0] VER     = 32'h0002_0000;
    localparam logic [31:0] CAPS    = 32'h0000_0104;

    logic         clk;
    logic         reset;
    logic [3:0]   address;
    logic         read;
    logic         write;
    logic [31:0]  writedata;
    logic [3:0]   byteenable;
    logic [31:0]  readdata;
    logic         readdatavalid;
    logic [127:0] user_status;
    logic         heartbeat;

    int n_tests = 0;
    int n_fail  = 0;

    sysid_regs #(
        .SYSTEM_ID (SYS_ID),
        .TIMESTAMP (TS),
        .VERSION   (VER),
        .NUM_USER  (4),
        .ADDR_W    (4),
        .HB_DIV    (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .address       (address),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .byteenable    (byteenable),
        .readdata      (readdata),
        .readdatavalid (readdatavalid),
        .user_status   (user_status),
        .heartbeat     (heartbeat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[22];

    function automatic vec_t mk(input logic rd, input logic wr, input logic [3:0] addr,
                                input logic [31:0] wdata, input logic [3:0] be,
                                input logic [31:0] exp);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.be = be; v.exp = exp;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge: drive one operation, sample the response at the next negedge.
    task automatic op(input logic r, input logic w, input logic [3:0] a,
                      input logic [31:0] wd, input logic [3:0] be,
                      output logic [31:0] rd, output logic v);
        read = r; write = w; address = a; writedata = wd; byteenable = be;
        @(negedge clk);
        read = 1'b0; write = 1'b0;
        v  = readdatavalid;
        rd = readdata;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] rdat;
        logic        rv;
        logic [31:0] prev;
        logic [31:0] lo_a;
        logic [31:0] lo_b;

        reset = 1'b1; read = 1'b0; write = 1'b0; address = 4'h0;
        writedata = 32'h0; byteenable = 4'h0; user_status = 128'h0;

        vecs[0]  = mk(1, 0, 4'd0,  32'h0,         4'h0, SYS_ID);
        vecs[1]  = mk(1, 0, 4'd1,  32'h0,         4'h0, TS);
        vecs[2]  = mk(1, 0, 4'd2,  32'h0,         4'h0, VER);
        vecs[3]  = mk(1, 0, 4'd3,  32'h0,         4'h0, CAPS);
        vecs[4]  = mk(1, 0, 4'd4,  32'h0,         4'h0, 32'h0);
        vecs[5]  = mk(1, 0, 4'd7,  32'h0,         4'h0, 32'h0);
        vecs[6]  = mk(0, 1, 4'd4,  32'hA5A5_A5A5, 4'hF, 32'h0);
        vecs[7]  = mk(0, 1, 4'd4,  32'h1234_5678, 4'h5, 32'h0);
        vecs[8]  = mk(1, 0, 4'd4,  32'h0,         4'h0, 32'hA534_A578);
        vecs[9]  = mk(1, 1, 4'd4,  32'h0,         4'hF, 32'hA534_A578);
        vecs[10] = mk(1, 0, 4'd4,  32'h0,         4'h0, 32'h0);
        vecs[11] = mk(0, 1, 4'd0,  32'hFFFF_FFFF, 4'hF, 32'h0);
        vecs[12] = mk(1, 0, 4'd0,  32'h0,         4'h0, SYS_ID);
        vecs[13] = mk(0, 1, 4'd7,  32'h3,         4'h0, 32'h0);
        vecs[14] = mk(1, 0, 4'd7,  32'h0,         4'h0, 32'h0);
        vecs[15] = mk(1, 0, 4'd15, 32'h0,         4'h0, 32'h0);
        vecs[16] = mk(1, 0, 4'd9,  32'h0,         4'h0, 32'h0);
        vecs[17] = mk(0, 1, 4'd4,  32'hFFFF_FFFF, 4'h8, 32'h0);
        vecs[18] = mk(1, 0, 4'd4,  32'h0,         4'h0, 32'hFF00_0000);
        vecs[19] = mk(0, 1, 4'd3,  32'h0,         4'hF, 32'h0);
        vecs[20] = mk(1, 0, 4'd3,  32'h0,         4'h0, CAPS);
        vecs[21] = mk(1, 0, 4'd6,  32'h0,         4'h0, 32'h0);

        repeat (3) @(negedge clk);
        check("reset_rdv",  {31'b0, readdatavalid}, 32'h0);
        check("reset_rdat", readdata,               32'h0);
        check("reset_hb",   {31'b0, heartbeat},     32'h0);

        // Heartbeat: first rise on the 4th edge after release, fall on the 8th.
        reset = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            check($sformatf("hb_cycle%0d", i), {31'b0, heartbeat},
                  {31'b0, (i >= 4 && i < 8)});
        end

        prev = 32'h0;
        for (int i = 0; i < 22; i++) begin
            op(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be, rdat, rv);
            check($sformatf("vec%0d_valid", i), {31'b0, rv}, {31'b0, vecs[i].rd});
            if (vecs[i].rd) begin
                check($sformatf("vec%0d_data", i), rdat, vecs[i].exp);
                prev = vecs[i].exp;
            end else begin
                check($sformatf("vec%0d_hold", i), rdat, prev);
            end
        end
        op(0, 0, 4'd0, 32'h0, 4'h0, rdat, rv);
        check("single_pulse", {31'b0, rv}, 32'h0);

        // Uptime snapshot across the 32-bit carry.
        force dut.u_uptime.count = 64'h0000_0000_FFFF_FFFF;
        op(1, 0, 4'd5, 32'h0, 4'h0, rdat, rv);
        release dut.u_uptime.count;
        check("wrap_lo", rdat, 32'hFFFF_FFFF);
        op(0, 0, 4'd0, 32'h0, 4'h0, rdat, rv);
        op(1, 0, 4'd6, 32'h0, 4'h0, rdat, rv);
        check("wrap_hi_shadow", rdat, 32'h0);
        op(1, 0, 4'd5, 32'h0, 4'h0, lo_a, rv);
        check("wrap_lo_after", {31'b0, (lo_a < 32'd8)}, 32'h1);
        op(1, 0, 4'd6, 32'h0, 4'h0, rdat, rv);
        check("wrap_hi_after", rdat, 32'h1);

        // Freeze, then clear while frozen (bit1 kept set so freeze stays on).
        op(0, 1, 4'd7, 32'h2, 4'h1, rdat, rv);
        repeat (10) @(negedge clk);
        op(1, 0, 4'd5, 32'h0, 4'h0, lo_a, rv);
        op(1, 0, 4'd5, 32'h0, 4'h0, lo_b, rv);
        check("freeze_hold", lo_b, lo_a);
        op(0, 1, 4'd7, 32'h3, 4'h1, rdat, rv);
        op(1, 0, 4'd5, 32'h0, 4'h0, rdat, rv);
        check("clear_frozen_lo", rdat, 32'h0);
        op(1, 0, 4'd6, 32'h0, 4'h0, rdat, rv);
        check("clear_shadow", rdat, 32'h0);
        op(1, 0, 4'd7, 32'h0, 4'h0, rdat, rv);
        check("control_read", rdat, 32'h2);
        op(0, 1, 4'd7, 32'h0, 4'hF, rdat, rv);
        op(1, 0, 4'd5, 32'h0, 4'h0, rdat, rv);
        check("resume_lo0", rdat, 32'h0);
        op(1, 0, 4'd5, 32'h0, 4'h0, rdat, rv);
        check("resume_lo1", rdat, 32'h1);
        repeat (5) @(negedge clk);
        op(0, 1, 4'd7, 32'h1, 4'h1, rdat, rv);
        op(1, 0, 4'd5, 32'h0, 4'h0, rdat, rv);
        check("clear_running", rdat, 32'h0);

        // User status: one-cycle sampling delay.
        user_status = {32'hDEAD_BEEF, 32'hCAFE_0002, 32'h0000_1111, 32'h0};
        op(0, 0, 4'd0, 32'h0, 4'h0, rdat, rv);
        op(1, 0, 4'd10, 32'h0, 4'h0, rdat, rv);
        check("user2", rdat, 32'hCAFE_0002);
        op(1, 0, 4'd11, 32'h0, 4'h0, rdat, rv);
        check("user3", rdat, 32'hDEAD_BEEF);
        user_status[95:64] = 32'h0000_1234;
        op(1, 0, 4'd10, 32'h0, 4'h0, rdat, rv);
        check("user2_delay", rdat, 32'hCAFE_0002);
        op(1, 0, 4'd10, 32'h0, 4'h0, rdat, rv);
        check("user2_new", rdat, 32'h0000_1234);
        op(1, 0, 4'd15, 32'h0, 4'h0, rdat, rv);
        check("unmapped15", rdat, 32'h0);
        op(1, 0, 4'd12, 32'h0, 4'h0, rdat, rv);
        check("unmapped12", rdat, 32'h0);

        // Reset lands while a read response is pending.
        read = 1'b1; address = 4'd0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        read  = 1'b0;
        #1;
        check("rst_drop_rdv",  {31'b0, readdatavalid}, 32'h0);
        check("rst_drop_rdat", readdata,               32'h0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check($sformatf("post_rst_rdv%0d", i), {31'b0, readdatavalid}, 32'h0);
            check($sformatf("post_rst_hb%0d", i),  {31'b0, heartbeat}, {31'b0, (i == 4)});
        end
        check("post_rst_rdat", readdata, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
